// File: rtl/w5300_cycle.sv
// Z80 -> W5300 8-bit bus-cycle sequencer with programmable setup/strobe/hold timing.
// Optional Z80 /WAIT generation is enabled by defining W5300_ZWAIT_EN.
module w5300_cycle #(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 1
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       z_rd_n,
  input  logic       z_wr_n,
  input  logic       sel,
  input  logic [9:0] map_addr,
  input  logic [7:0] z_din,
  input  logic [7:0] w_din,
  output logic [9:0] w_addr,
  output logic       w_cs_n,
  output logic       w_rd_n,
  output logic       w_wr_n,
  output logic [7:0] w_dout,
  output logic       w_doe,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       zwait_n
);

  localparam int unsigned TMax12 = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int unsigned TMax   = (TMax12 > T_HOLD) ? TMax12 : T_HOLD;
  localparam int unsigned CntW   = $clog2(TMax + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;  // 1 = write
  logic [9:0]      addr_q, addr_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      rdat_q, rdat_d;
  logic            cs_n_q, cs_n_d;
  logic            rd_n_q, rd_n_d;
  logic            wr_n_q, wr_n_d;
  logic            doe_q, doe_d;

  // Two-flop synchronisers plus one delay stage for falling-edge detection.
  logic rd_meta_q, rd_s_q, rd_p_q;
  logic wr_meta_q, wr_s_q, wr_p_q;
  logic rd_fall, wr_fall, start, strobe_end;

  assign rd_fall    = rd_p_q & ~rd_s_q;
  assign wr_fall    = wr_p_q & ~wr_s_q;
  // Simultaneous read and write falls are illegal and ignored.
  assign start      = (state_q == StIdle) & sel & (rd_fall ^ wr_fall);
  assign strobe_end = (state_q == StStrobe) & (cnt_q == '0);

  always_ff @(posedge fclk) begin
    if (rst) begin
      rd_meta_q <= 1'b1;
      rd_s_q    <= 1'b1;
      rd_p_q    <= 1'b1;
      wr_meta_q <= 1'b1;
      wr_s_q    <= 1'b1;
      wr_p_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      rdat_q    <= '0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      doe_q     <= 1'b0;
    end else begin
      rd_meta_q <= z_rd_n;
      rd_s_q    <= rd_meta_q;
      rd_p_q    <= rd_s_q;
      wr_meta_q <= z_wr_n;
      wr_s_q    <= wr_meta_q;
      wr_p_q    <= wr_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rdat_q    <= rdat_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      doe_q     <= doe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdat_d  = rdat_q;
    cs_n_d  = cs_n_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    doe_d   = doe_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          cnt_d   = CntW'(T_SETUP - 1);
          dir_d   = wr_fall;
          addr_d  = map_addr;
          cs_n_d  = 1'b0;
          if (wr_fall) begin
            dout_d = z_din;
            doe_d  = 1'b1;
          end
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = CntW'(T_STROBE - 1);
          if (dir_q) wr_n_d = 1'b0;
          else       rd_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        if (strobe_end) begin
          state_d = StHold;
          cnt_d   = CntW'(T_HOLD - 1);
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          if (!dir_q) rdat_d = w_din;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          cs_n_d  = 1'b1;
          doe_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        // Stay here until the Z80 ends its bus cycle so one cycle never triggers twice.
        if (dir_q ? wr_s_q : rd_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef W5300_ZWAIT_EN
  logic zwait_q;
  always_ff @(posedge fclk) begin
    if (rst)             zwait_q <= 1'b1;
    else if (start)      zwait_q <= 1'b0;
    else if (strobe_end) zwait_q <= 1'b1;
  end
  assign zwait_n = zwait_q;
`else
  assign zwait_n = 1'b1;
`endif

  assign w_addr  = addr_q;
  assign w_cs_n  = cs_n_q;
  assign w_rd_n  = rd_n_q;
  assign w_wr_n  = wr_n_q;
  assign w_dout  = dout_q;
  assign w_doe   = doe_q;
  assign rd_data = rdat_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_w5300_cycle.sv
// Scoreboard bench for w5300_cycle: stimulus pushes expected W5300 cycles, a monitor
// measures each /CS window and compares it when /CS rises.
module tb_w5300_cycle;

  logic       fclk = 1'b0;
  logic       rst, z_rd_n, z_wr_n, sel;
  logic [9:0] map_addr;
  logic [7:0] z_din, w_din;
  logic [9:0] w_addr;
  logic       w_cs_n, w_rd_n, w_wr_n, w_doe, busy, zwait_n;
  logic [7:0] w_dout, rd_data;

  w5300_cycle dut (
    .fclk    (fclk),
    .rst     (rst),
    .z_rd_n  (z_rd_n),
    .z_wr_n  (z_wr_n),
    .sel     (sel),
    .map_addr(map_addr),
    .z_din   (z_din),
    .w_din   (w_din),
    .w_addr  (w_addr),
    .w_cs_n  (w_cs_n),
    .w_rd_n  (w_rd_n),
    .w_wr_n  (w_wr_n),
    .w_dout  (w_dout),
    .w_doe   (w_doe),
    .rd_data (rd_data),
    .busy    (busy),
    .zwait_n (zwait_n)
  );

  always #5 fclk = ~fclk;

`ifdef W5300_ZWAIT_EN
  localparam int ExpZw = 6;
`else
  localparam int ExpZw = 0;
`endif

  typedef struct {
    logic       wr;
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  // Monitor: accumulate one /CS window, compare against the scoreboard when it closes.
  logic       prev_cs_low = 1'b0;
  int         setup_c, rd_c, wr_c, hold_c, doe_c, zw_c;
  logic [9:0] addr_s;
  logic [7:0] dout_s;
  logic       dout_chg;
  exp_t       e;

  always @(negedge fclk) begin
    if (rst) begin
      prev_cs_low = 1'b0;
      zw_c        = 0;
    end else begin
      if (!w_cs_n) begin
        if (!prev_cs_low) begin
          setup_c = 0; rd_c = 0; wr_c = 0; hold_c = 0; doe_c = 0;
          addr_s = w_addr; dout_s = w_dout; dout_chg = 1'b0;
        end
        if (!w_rd_n) rd_c++;
        if (!w_wr_n) wr_c++;
        if (w_rd_n && w_wr_n) begin
          if (rd_c == 0 && wr_c == 0) setup_c++;
          else hold_c++;
        end
        if (w_doe) doe_c++;
        if (w_dout !== dout_s || w_addr !== addr_s) dout_chg = 1'b1;
      end
      if (!zwait_n) zw_c++;
      if (prev_cs_low && w_cs_n) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cycle", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("addr", {22'd0, addr_s}, {22'd0, e.addr});
          chk("setup_clk", setup_c, 2);
          chk("strobe_clk", e.wr ? wr_c : rd_c, 4);
          chk("other_strobe_clk", e.wr ? rd_c : wr_c, 0);
          chk("hold_clk", hold_c, 1);
          chk("doe_clk", doe_c, e.wr ? 7 : 0);
          chk("stable_in_cs", {31'd0, dout_chg}, 0);
          if (e.wr) chk("w_dout", {24'd0, dout_s}, {24'd0, e.data});
          else      chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
          chk("zwait_low_clk", zw_c, ExpZw);
        end
        zw_c = 0;
      end
      prev_cs_low = !w_cs_n;
    end
  end

  // One Z80 access; the strobe is held `extra` clocks after the W5300 cycle ends.
  task automatic do_access(input logic wr, input logic [9:0] a, input logic [7:0] d,
                           input int extra);
    int n;
    exp_t x;
    @(negedge fclk);
    map_addr = a; sel = 1'b1;
    if (wr) z_din = d; else w_din = d;
    x.wr = wr; x.addr = a; x.data = d;
    exp_q.push_back(x);
    if (wr) z_wr_n = 1'b0; else z_rd_n = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge fclk); n++; end
    chk("busy_rise", {31'd0, busy}, 1);
    // Changing these mid-cycle must not disturb the access.
    map_addr = ~a; z_din = ~z_din; sel = 1'b0;
    n = 0;
    while (!w_cs_n && n < 30) begin @(negedge fclk); n++; end
    chk("cs_release", {31'd0, w_cs_n}, 1);
    repeat (extra) @(negedge fclk);
    chk("busy_in_done", {31'd0, busy}, 1);
    z_rd_n = 1'b1; z_wr_n = 1'b1;
    n = 0;
    while (busy && n < 10) begin @(negedge fclk); n++; end
    chk("busy_fall", {31'd0, busy}, 0);
    repeat (2) @(negedge fclk);
  endtask

  // Drive strobes low for 10 clocks and verify no W5300 cycle starts.
  task automatic ignored(input string nm, input logic rd, input logic wr, input logic s);
    logic seen;
    seen = 1'b0;
    @(negedge fclk);
    sel = s; map_addr = 10'h111;
    z_rd_n = ~rd; z_wr_n = ~wr;
    repeat (10) begin
      @(negedge fclk);
      if (busy || !w_cs_n) seen = 1'b1;
    end
    chk(nm, {31'd0, seen}, 0);
    z_rd_n = 1'b1; z_wr_n = 1'b1;
    repeat (4) @(negedge fclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n;

  initial begin
    rst = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1; sel = 1'b0;
    map_addr = '0; z_din = '0; w_din = '0;
    repeat (2) @(negedge fclk);
    chk("rst_cs_n", {31'd0, w_cs_n}, 1);
    chk("rst_rd_n", {31'd0, w_rd_n}, 1);
    chk("rst_wr_n", {31'd0, w_wr_n}, 1);
    chk("rst_doe", {31'd0, w_doe}, 0);
    chk("rst_addr", {22'd0, w_addr}, 0);
    chk("rst_dout", {24'd0, w_dout}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_zwait", {31'd0, zwait_n}, 1);
    rst = 1'b0;
    repeat (3) @(negedge fclk);

    do_access(1'b0, 10'h2A5, 8'h5C, 0);
    do_access(1'b1, 10'h155, 8'hA3, 0);
    ignored("sel0_no_cycle", 1'b1, 1'b0, 1'b0);
    ignored("rdwr_no_cycle", 1'b1, 1'b1, 1'b1);
    do_access(1'b0, 10'h003, 8'hE1, 20);
    do_access(1'b0, 10'h3C0, 8'h17, 0);

    // Reset while /RD is low aborts the cycle on the same edge.
    @(negedge fclk);
    map_addr = 10'h0F0; sel = 1'b1; z_rd_n = 1'b0;
    n = 0;
    while (w_rd_n && n < 20) begin @(negedge fclk); n++; end
    chk("mid_rd_low", {31'd0, w_rd_n}, 0);
    rst = 1'b1; z_rd_n = 1'b1;
    @(negedge fclk);
    chk("mid_rst_cs_n", {31'd0, w_cs_n}, 1);
    chk("mid_rst_rd_n", {31'd0, w_rd_n}, 1);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge fclk);
    chk("mid_rst_addr", {22'd0, w_addr}, 0);
    rst = 1'b0;
    repeat (3) @(negedge fclk);

    do_access(1'b1, 10'h2FF, 8'h3C, 0);
    chk("pending_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
